// File: rtl/fr_round_pack.sv
// Final rounding and IEEE-754 single-precision packing for the float pipeline.
// Two-stage valid/ready pipeline: round, then pack with exception handling.
module fr_round_pack #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [24:0] in_significand,
  input  logic [7:0]  in_exponent,
  input  logic        in_sticky,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic [2:0]  flag_acc,
  input  logic        flag_clear
);

  // Returns {exp9, frac, inexact, underflow}; exp9 carries a possible round-up overflow.
  function automatic logic [33:0] round_fn(input logic [24:0] sig,
                                           input logic [7:0]  expo,
                                           input logic        sticky);
    logic [22:0] frac;
    logic        guard;
    logic        up;
    logic [23:0] sum;
    logic [8:0]  exp9;
    if (sig[24]) begin
      frac  = sig[23:1];
      guard = sig[0];
    end else begin
      frac  = sig[22:0];
      guard = 1'b0;
    end
    up   = ROUND_EN && guard && (sticky || frac[0]);
    sum  = {1'b0, frac} + {23'd0, up};
    exp9 = {1'b0, expo} + {8'd0, sum[23]};
    return {exp9, sum[22:0], guard | sticky, (expo == 8'd0)};
  endfunction

  // Returns {overflow, underflow, inexact, packed_word}.
  function automatic logic [34:0] pack_fn(input logic        sign,
                                          input logic [8:0]  exp9,
                                          input logic [22:0] frac,
                                          input logic        inexact,
                                          input logic        uflow,
                                          input logic        zero);
    if (zero)
      return {3'b000, sign, 31'd0};
    else if (uflow)
      return {3'b011, sign, 31'd0};
    else if (exp9 >= 9'd255)
      return {3'b101, sign, 8'hFF, 23'd0};
    else
      return {2'b00, inexact, sign, exp9[7:0], frac};
  endfunction

  logic        vld_p1;
  logic        sign_p1;
  logic [8:0]  exp_p1;
  logic [22:0] frac_p1;
  logic        inexact_p1;
  logic        uflow_p1;
  logic        zero_p1;
  logic        vld_p2;
  logic        adv_p2;
  logic [33:0] rnd;

  always_comb begin
    adv_p2    = !vld_p2 || out_ready;
    in_ready  = !vld_p1 || adv_p2;
    out_valid = vld_p2;
    rnd       = round_fn(in_significand, in_exponent, in_sticky);
  end

  // Stage p1: round the accepted input
  always_ff @(posedge clock) begin
    if (in_ready && in_valid) begin
      sign_p1    <= in_sign;
      zero_p1    <= in_zero;
      exp_p1     <= rnd[33:25];
      frac_p1    <= rnd[24:2];
      inexact_p1 <= rnd[1];
      uflow_p1   <= rnd[0];
    end
  end

  // Stage p2: pack, apply exceptions, hold while downstream stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      out_result <= 32'd0;
      out_flags  <= 3'd0;
      flag_acc   <= 3'd0;
    end else begin
      if (in_ready)
        vld_p1 <= in_valid;
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1)
          {out_flags, out_result} <= pack_fn(sign_p1, exp_p1, frac_p1,
                                             inexact_p1, uflow_p1, zero_p1);
      end
      if (flag_clear)
        flag_acc <= 3'd0;
      else if (vld_p2 && out_ready)
        flag_acc <= flag_acc | out_flags;
    end
  end

endmodule

// File: tb/tb_fr_round_pack.sv
// Scoreboard bench for fr_round_pack: driver queues model predictions,
// a monitor pops them at each output handshake and tracks the flag accumulator.
module tb_fr_round_pack;
  localparam bit ROUND_EN = 1'b1;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [24:0] in_significand;
  logic [7:0]  in_exponent;
  logic        in_sticky;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [2:0]  flag_acc;
  logic        flag_clear;

  fr_round_pack #(.ROUND_EN(ROUND_EN)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_significand(in_significand), .in_exponent(in_exponent),
    .in_sticky(in_sticky), .in_zero(in_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .flag_acc(flag_acc), .flag_clear(flag_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  logic [34:0] q[$];
  logic [2:0]  acc_m = 3'd0;
  bit          rand_ready = 1'b0;
  bit          rand_clear = 1'b0;
  int          post_reset_outputs = 0;

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: treat the significand as an integer mantissa and round it numerically.
  function automatic logic [34:0] model(input logic s, input logic [24:0] sg,
                                        input logic [7:0] e, input logic st,
                                        input logic z);
    int unsigned m;
    int unsigned g;
    int          ex;
    logic        inx;
    logic [31:0] mv;
    if (z) return {3'b000, s, 31'd0};
    if (e == 8'd0) return {3'b011, s, 31'd0};
    if (sg[24]) begin
      m = int'(sg) / 2;
      g = int'(sg) % 2;
    end else begin
      m = int'(sg) % (1 << 24);
      g = 0;
    end
    ex  = int'(e);
    inx = (g != 0) || st;
    if (ROUND_EN && g != 0 && (st || (m % 2) == 1)) m = m + 1;
    if (m >= (1 << 24)) begin
      m  = m / 2;
      ex = ex + 1;
    end
    if (ex >= 255) return {3'b101, s, 8'hFF, 23'd0};
    mv = m;
    return {2'b00, inx, s, ex[7:0], mv[22:0]};
  endfunction

  task automatic gen(output logic s, output logic [24:0] sg, output logic [7:0] e,
                     output logic st, output logic z);
    logic [31:0] r;
    r  = $urandom;
    s  = r[31];
    st = r[30];
    z  = (r[29:26] == 4'd0);
    case ($urandom % 6)
      0: e = 8'h00;
      1: e = 8'hFF;
      2: e = 8'hFE;
      default: e = 8'($urandom_range(1, 254));
    endcase
    r = $urandom;
    if (r[31]) sg = {1'b1, r[23:0]};
    else       sg = {2'b01, r[22:0]};
    if (($urandom % 4) == 0) sg[22:1] = '1;
  endtask

  task automatic offer(input logic s, input logic [24:0] sg, input logic [7:0] e,
                       input logic st, input logic z, input logic [34:0] expv);
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 60) begin
      @(negedge clock);
      in_valid = 1'b1; in_sign = s; in_significand = sg;
      in_exponent = e; in_sticky = st; in_zero = z;
      #2;
      n++;
      if (in_ready) begin
        ok = 1'b1;
        q.push_back(expv);
      end
    end
    if (!ok) check("offer_timeout", 35'd0, 35'd1);
  endtask

  task automatic offer_rand();
    logic s, st, z;
    logic [24:0] sg;
    logic [7:0] e;
    gen(s, sg, e, st, z);
    offer(s, sg, e, st, z, model(s, sg, e, st, z));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clock);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    #4;
    check("drain_empty", 35'(q.size()), 35'd0);
  endtask

  always @(negedge clock) begin
    if (rand_ready) out_ready = ($urandom % 4) != 0;
    flag_clear = rand_clear && (($urandom % 16) == 0);
  end

  // Monitor: samples between the driver sample point and the next rising edge.
  always begin
    logic [34:0] e;
    logic [2:0]  f;
    bit          hs;
    @(negedge clock);
    #3;
    if (reset) begin
      q.delete();
      acc_m = 3'd0;
    end else begin
      check("flag_acc", {32'd0, flag_acc}, {32'd0, acc_m});
      hs = out_valid && out_ready;
      f  = 3'd0;
      if (out_valid) post_reset_outputs++;
      if (hs) begin
        if (q.size() == 0) begin
          check("unexpected_output", {out_flags, out_result}, 35'h7_FFFF_FFFF);
          f = out_flags;
        end else begin
          e = q.pop_front();
          check("result", {out_flags, out_result}, e);
          f = e[34:32];
        end
      end
      if (flag_clear) acc_m = 3'd0;
      else if (hs)    acc_m = acc_m | f;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int cnt;
    logic s, st, z;
    logic [24:0] sg;
    logic [7:0] e;
    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_significand = '0;
    in_exponent = '0; in_sticky = 1'b0; in_zero = 1'b0; out_ready = 1'b1;
    flag_clear = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_out_valid", {34'd0, out_valid}, 35'd0);
    check("rst_out_result", {3'd0, out_result}, 35'd0);
    check("rst_out_flags", {32'd0, out_flags}, 35'd0);
    check("rst_flag_acc", {32'd0, flag_acc}, 35'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_in_ready", {34'd0, in_ready}, 35'd1);

    offer(1'b0, 25'h0C00000, 8'h7F, 1'b0, 1'b0, {3'b000, 32'h3FC00000});
    offer(1'b0, 25'h1000001, 8'h80, 1'b0, 1'b0, {3'b001, 32'h40000000});
    offer(1'b0, 25'h1000003, 8'h80, 1'b0, 1'b0, {3'b001, 32'h40000002});
    offer(1'b0, 25'h1FFFFFF, 8'h7F, 1'b0, 1'b0, {3'b001, 32'h40000000});
    offer(1'b0, 25'h1FFFFFF, 8'hFE, 1'b0, 1'b0, {3'b101, 32'h7F800000});
    offer(1'b1, 25'h0C00000, 8'h00, 1'b0, 1'b0, {3'b011, 32'h80000000});
    offer(1'b0, 25'h1FFFFFF, 8'hFE, 1'b1, 1'b1, {3'b000, 32'h00000000});
    offer(1'b1, 25'h0800000, 8'h01, 1'b1, 1'b0, {3'b001, 32'h80800000});
    drain();

    // Clear with no handshake pending, then a clear coinciding with a handshake
    @(negedge clock); flag_clear = 1'b1;
    @(negedge clock); flag_clear = 1'b0;
    offer(1'b0, 25'h1FFFFFF, 8'hFE, 1'b0, 1'b0, {3'b101, 32'h7F800000});
    @(negedge clock); in_valid = 1'b0;
    @(negedge clock); flag_clear = 1'b1;
    @(negedge clock); flag_clear = 1'b0;
    drain();

    // Downstream stall: only two inputs fit
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) out_ready = 1'b0;
      gen(s, sg, e, st, z);
      in_valid = 1'b1; in_sign = s; in_significand = sg;
      in_exponent = e; in_sticky = st; in_zero = z;
      #2;
      if (in_ready) begin
        cnt++;
        q.push_back(model(s, sg, e, st, z));
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    #2;
    check("stall_in_ready", {34'd0, in_ready}, 35'd0);
    check("stall_accepted", 35'(cnt), 35'd2);
    drain();

    rand_ready = 1'b1;
    rand_clear = 1'b1;
    for (int i = 0; i < 400; i++) begin
      offer_rand();
      if (($urandom % 5) == 0) idle($urandom_range(1, 3));
    end
    rand_clear = 1'b0;
    drain();

    // Reset with both stages full
    offer(1'b0, 25'h1000001, 8'h80, 1'b0, 1'b0, {3'b001, 32'h40000000});
    drain();
    @(negedge clock);
    out_ready = 1'b0;
    offer_rand();
    offer_rand();
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_mid_out_valid", {34'd0, out_valid}, 35'd0);
    check("rst_mid_flag_acc", {32'd0, flag_acc}, 35'd0);
    check("rst_mid_in_ready", {34'd0, in_ready}, 35'd1);
    post_reset_outputs = 0;
    idle(6);
    #4;
    check("rst_mid_no_stale", 35'(post_reset_outputs), 35'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
